// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the IF stage: fetch FSM encoding, the canonical NOP
// and the reset vector, plus a small helper for word-aligning redirects.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_FETCH   = 2'd0,  // issuing or waiting on a request
    IF_DISCARD = 2'd1,  // in-flight request is wrong-path, waiting for it to drop
    IF_HOLD    = 2'd2   // fetched word parked in skid buffer, no request
  } if_state_t;

  // Redirect targets are word addresses; the low two bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears to NOP/0)
//   bubble            load a NOP with valid=0, PC fields unchanged (wins over load)
//   load              capture instr_in/pc_in/pc_plus_4_in with valid=1
//   instr/pc/pc_plus_4/valid  registered IF/ID contents
// With neither bubble nor load the contents are held.
module if_id_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus_4_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr     <= NOP;
      pc        <= '0;
      pc_plus_4 <= '0;
      valid     <= 1'b0;
    end else if (bubble) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      instr     <= instr_in;
      pc        <= pc_in;
      pc_plus_4 <= pc_plus_4_in;
      valid     <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the fetch PC, talks to instruction memory over a busy/ready
// handshake, and loads the IF/ID register. A one-entry skid buffer absorbs a
// word that completes while decode is stalled; a DISCARD state drops a
// wrong-path request that was still busy when a redirect arrived.
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   STALL                       hold IF/ID and PC (from hazard unit)
//   BRANCH_TAKEN, BRANCH_TARGET redirect from EX (flushes IF/ID)
//   IMEM_ADDRESS, IMEM_READ     fetch request (address stable while busy)
//   IMEM_READDATA, IMEM_BUSY    memory response; completion = READ & ~BUSY
//   INSTRUCTION, PC, PC_PLUS_4, VALID   IF/ID register outputs
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSY,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        VALID
);

  if_state_t   state;
  logic [31:0] fetch_pc;
  logic [31:0] pending_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] fetch_pc_p4;
  logic [31:0] target;
  logic        complete;

  logic        ifid_load;
  logic        ifid_bubble;
  logic [31:0] ifid_instr_in;
  logic [31:0] ifid_pc_in;
  logic [31:0] ifid_pc_plus_4_in;

  assign IMEM_READ    = (state != IF_HOLD);
  assign IMEM_ADDRESS = fetch_pc;
  assign complete     = IMEM_READ & ~IMEM_BUSY;
  assign fetch_pc_p4  = fetch_pc + 32'd4;  // wraps modulo 2^32
  assign target       = word_align(BRANCH_TARGET);

  // IF/ID control: a redirect always flushes; otherwise the state decides
  // whether a fresh word, the parked word, or a bubble goes to decode.
  always_comb begin
    ifid_load         = 1'b0;
    ifid_bubble       = 1'b0;
    ifid_instr_in     = IMEM_READDATA;
    ifid_pc_in        = fetch_pc;
    ifid_pc_plus_4_in = fetch_pc_p4;
    if (BRANCH_TAKEN) begin
      ifid_bubble = 1'b1;
    end else begin
      unique case (state)
        IF_FETCH: begin
          if (!STALL) begin
            ifid_load   = complete;
            ifid_bubble = ~complete;
          end
        end
        IF_DISCARD: ifid_bubble = ~STALL;
        IF_HOLD: begin
          ifid_load         = ~STALL;
          ifid_instr_in     = skid_instr;
          ifid_pc_in        = skid_pc;
          ifid_pc_plus_4_in = skid_pc + 32'd4;
        end
        default: ifid_bubble = ~STALL;
      endcase
    end
  end

  // Fetch FSM, PC and skid buffer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IF_FETCH;
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      skid_instr <= NOP;
      skid_pc    <= '0;
    end else if (BRANCH_TAKEN) begin
      // The address must not move under a busy request, so park the target
      // until that request drops; otherwise redirect immediately.
      if (state != IF_HOLD && IMEM_BUSY) begin
        pending_pc <= target;
        state      <= IF_DISCARD;
      end else begin
        fetch_pc <= target;
        state    <= IF_FETCH;
      end
    end else begin
      unique case (state)
        IF_FETCH: begin
          if (complete) begin
            fetch_pc <= fetch_pc_p4;
            if (STALL) begin
              skid_instr <= IMEM_READDATA;
              skid_pc    <= fetch_pc;
              state      <= IF_HOLD;
            end
          end
        end
        IF_DISCARD: begin
          if (!IMEM_BUSY) begin
            fetch_pc <= pending_pc;
            state    <= IF_FETCH;
          end
        end
        IF_HOLD: begin
          if (!STALL) state <= IF_FETCH;
        end
        default: state <= IF_FETCH;
      endcase
    end
  end

  if_id_register u_if_id (
    .clk          (CLK),
    .rst          (RESET),
    .load         (ifid_load),
    .bubble       (ifid_bubble),
    .instr_in     (ifid_instr_in),
    .pc_in        (ifid_pc_in),
    .pc_plus_4_in (ifid_pc_plus_4_in),
    .instr        (INSTRUCTION),
    .pc           (PC),
    .pc_plus_4    (PC_PLUS_4),
    .valid        (VALID)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IMEM_ADDRESS;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSY;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic        VALID;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  always #5 CLK = ~CLK;

  // Memory image: mem[a] = a | 1
  assign IMEM_READDATA = IMEM_ADDRESS | 32'h1;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IMEM_ADDRESS  (IMEM_ADDRESS),
    .IMEM_READ     (IMEM_READ),
    .IMEM_READDATA (IMEM_READDATA),
    .IMEM_BUSY     (IMEM_BUSY),
    .INSTRUCTION   (INSTRUCTION),
    .PC            (PC),
    .PC_PLUS_4     (PC_PLUS_4),
    .VALID         (VALID)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET         = 1'b1;
    STALL         = 1'b0;
    BRANCH_TAKEN  = 1'b0;
    BRANCH_TARGET = 32'h0;
    IMEM_BUSY     = 1'b0;
    step();
    RESET = 1'b0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc_e, input logic v_e);
    check_eq({tag, "_valid"}, {31'b0, VALID}, {31'b0, v_e});
    check_eq({tag, "_pc"}, PC, pc_e);
    if (v_e) begin
      check_eq({tag, "_instr"}, INSTRUCTION, pc_e | 32'h1);
      check_eq({tag, "_pc4"}, PC_PLUS_4, pc_e + 32'd4);
    end
  endtask

  initial begin
    // Reset state and zero-wait streaming
    do_reset();
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_eq("rst_valid", {31'b0, VALID}, 32'h0);
    check_eq("rst_instr", INSTRUCTION, NOP_W);
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_pc4", PC_PLUS_4, 32'h0);
    check_eq("rst_addr", IMEM_ADDRESS, 32'h0);
    check_eq("rst_read", {31'b0, IMEM_READ}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_ifid("stream", 32'(4 * i), 1'b1);
    end

    // Memory busy 3 cycles on address 8
    do_reset();
    step();
    step();
    check_ifid("busy_pre", 32'h4, 1'b1);
    IMEM_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("busy_addr", IMEM_ADDRESS, 32'h8);
      step();
      check_ifid("busy_bubble", 32'h4, 1'b0);
    end
    IMEM_BUSY = 1'b0;
    check_eq("busy_addr_end", IMEM_ADDRESS, 32'h8);
    step();
    check_ifid("busy_done", 32'h8, 1'b1);
    step();
    check_ifid("busy_next", 32'hC, 1'b1);

    // Decode stall for 2 cycles with PC=4 in IF/ID
    do_reset();
    step();
    step();
    check_ifid("stall_pre", 32'h4, 1'b1);
    STALL = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_ifid("stall_hold", 32'h4, 1'b1);
      check_eq("stall_noreq", {31'b0, IMEM_READ}, 32'h0);
    end
    STALL = 1'b0;
    step();
    check_ifid("stall_skid", 32'h8, 1'b1);
    check_eq("stall_read", {31'b0, IMEM_READ}, 32'h1);
    check_eq("stall_addr", IMEM_ADDRESS, 32'hC);
    step();
    check_ifid("stall_next", 32'hC, 1'b1);

    // Redirect to 0x100 while the request to 0x10 is busy
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check_ifid("br_pre", 32'hC, 1'b1);
    check_eq("br_addr10", IMEM_ADDRESS, 32'h10);
    IMEM_BUSY = 1'b1;
    step();
    BRANCH_TAKEN  = 1'b1;
    BRANCH_TARGET = 32'h100;
    step();
    BRANCH_TAKEN = 1'b0;
    check_eq("br_flush_valid", {31'b0, VALID}, 32'h0);
    check_eq("br_hold_addr", IMEM_ADDRESS, 32'h10);
    step();
    check_eq("br_disc_valid", {31'b0, VALID}, 32'h0);
    IMEM_BUSY = 1'b0;
    step();
    check_eq("br_drop_valid", {31'b0, VALID}, 32'h0);
    check_eq("br_new_addr", IMEM_ADDRESS, 32'h100);
    step();
    check_ifid("br_target", 32'h100, 1'b1);

    // Redirect and stall together while in HOLD (unaligned target bits ignored)
    do_reset();
    step();
    STALL = 1'b1;
    step();
    check_eq("hold_noreq", {31'b0, IMEM_READ}, 32'h0);
    BRANCH_TAKEN  = 1'b1;
    BRANCH_TARGET = 32'h203;
    step();
    check_eq("hold_br_valid", {31'b0, VALID}, 32'h0);
    check_eq("hold_br_instr", INSTRUCTION, NOP_W);
    check_eq("hold_br_addr", IMEM_ADDRESS, 32'h200);
    check_eq("hold_br_read", {31'b0, IMEM_READ}, 32'h1);
    BRANCH_TAKEN = 1'b0;
    STALL        = 1'b0;
    step();
    check_ifid("hold_br_target", 32'h200, 1'b1);

    // Reset in the middle of DISCARD
    do_reset();
    step();
    IMEM_BUSY     = 1'b1;
    BRANCH_TAKEN  = 1'b1;
    BRANCH_TARGET = 32'h40;
    step();
    BRANCH_TAKEN = 1'b0;
    check_eq("disc_addr", IMEM_ADDRESS, 32'h4);
    RESET = 1'b1;
    step();
    RESET     = 1'b0;
    IMEM_BUSY = 1'b0;
    check_eq("disc_rst_addr", IMEM_ADDRESS, 32'h0);
    check_eq("disc_rst_read", {31'b0, IMEM_READ}, 32'h1);
    check_eq("disc_rst_valid", {31'b0, VALID}, 32'h0);
    step();
    check_ifid("disc_rst_first", 32'h0, 1'b1);

    // Zero-wait redirect timing and PC wrap at the top of memory
    do_reset();
    BRANCH_TAKEN  = 1'b1;
    BRANCH_TARGET = 32'hFFFF_FFFC;
    step();
    BRANCH_TAKEN = 1'b0;
    check_eq("wrap_addr", IMEM_ADDRESS, 32'hFFFF_FFFC);
    check_eq("wrap_flush", {31'b0, VALID}, 32'h0);
    step();
    check_eq("wrap_pc", PC, 32'hFFFF_FFFC);
    check_eq("wrap_instr", INSTRUCTION, 32'hFFFF_FFFD);
    check_eq("wrap_pc4", PC_PLUS_4, 32'h0);
    check_eq("wrap_next_addr", IMEM_ADDRESS, 32'h0);
    step();
    check_ifid("wrap_zero", 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

IF stage of the RV32IM pipeline. It owns the program counter, fetches 32-bit instructions from instruction memory over a busy/ready handshake, and loads the IF/ID pipeline register. That register feeds the decode stage's control unit and register file. The stage absorbs memory wait states, ID-stage stalls (through a one-entry skid buffer) and EX-stage branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CLK  in  1  clock, all state updates on posedge
- RESET  in  1  synchronous, active-high; all state cleared on a posedge with RESET=1
- STALL  in  1  from hazard unit; hold IF/ID contents and PC
- BRANCH_TAKEN  in  1  from EX; redirect fetch and flush IF/ID
- BRANCH_TARGET  in  32  redirect address (word aligned; bits [1:0] ignored, treated as 0)
- IMEM_ADDRESS  out  32  fetch address, held stable while IMEM_BUSY=1
- IMEM_READ  out  1  fetch request
- IMEM_READDATA  in  32  instruction word, valid on a completing cycle
- IMEM_BUSY  in  1  memory not done; completion = IMEM_READ & ~IMEM_BUSY
- INSTRUCTION  out  32  IF/ID instruction
- PC  out  32  IF/ID address of INSTRUCTION
- PC_PLUS_4  out  32  IF/ID PC+4 (JAL/JALR link value)
- VALID  out  1  IF/ID holds a real instruction

## Operation
- Registers: FETCH_PC (drives IMEM_ADDRESS), PENDING_PC, SKID_INSTR, SKID_PC, state, and the IF/ID register set.
- States:
  - FETCH: issuing or waiting on a request.
  - DISCARD: an in-flight request is wrong-path; wait for it to drop.
  - HOLD: a fetched word is parked in the skid buffer; no request issued.
- IMEM_READ = (state != HOLD); IMEM_ADDRESS = FETCH_PC.
- Per-posedge priority: RESET > BRANCH_TAKEN > STALL > normal.
- RESET:
  - FETCH_PC=RESET_PC, state=FETCH.
  - INSTRUCTION=`NOP (32'h0000_0013), PC=0, PC_PLUS_4=0, VALID=0.
- BRANCH_TAKEN (any state, with or without STALL):
  - IF/ID flushed to NOP with VALID=0.
  - Skid buffer dropped.
  - If the current request is busy (state FETCH or DISCARD with IMEM_BUSY=1): PENDING_PC=target, go to DISCARD.
  - Otherwise: FETCH_PC=target, go to FETCH; a same-cycle completion is discarded.
- FETCH, completion, STALL=0: IF/ID={IMEM_READDATA, FETCH_PC, FETCH_PC+4}, VALID=1; FETCH_PC+=4.
- FETCH, completion, STALL=1: SKID={data, FETCH_PC}; FETCH_PC+=4; go to HOLD; IF/ID held.
- FETCH, busy, STALL=0: IF/ID loads a bubble (NOP, VALID=0; PC fields unchanged).
- FETCH, busy, STALL=1: IF/ID held.
- DISCARD:
  - On ~IMEM_BUSY: returned data dropped; FETCH_PC=PENDING_PC; go to FETCH.
  - IF/ID gets a bubble unless STALL=1.
  - A further redirect overwrites PENDING_PC.
- HOLD:
  - While STALL=1: hold.
  - When STALL=0: IF/ID=SKID contents with VALID=1; go to FETCH.
- Arithmetic: FETCH_PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no flag.

## Timing
- Zero-wait memory:
  - Address presented in cycle N; instruction in IF/ID in cycle N+1.
  - Throughput is 1 instruction/cycle.
- Redirect:
  - BRANCH_TAKEN in cycle N gives IMEM_ADDRESS=target in N+1 and the target instruction VALID in N+2.
  - 2 bubbles, counting the flushed IF/ID.
- Wait states: each busy cycle inserts one bubble; IMEM_ADDRESS never changes while IMEM_BUSY=1.
- After RESET deasserts: the first request goes to RESET_PC in that same cycle. Memory is reset by the same RESET, so any in-flight transaction is abandoned.
- No instruction is lost or duplicated across any stall/busy/redirect combination.

## Structure
- Support_Files/definitions.v gains:
  - `NOP (32'h0000_0013)
  - state encodings `IF_FETCH, `IF_DISCARD, `IF_HOLD
  - `RESET_VECTOR
- Sub-module if_id_register holds INSTRUCTION/PC/PC_PLUS_4/VALID, with load, bubble and hold controls and synchronous reset.
- The FSM, PC logic and skid buffer live in instruction_fetch_unit.

## Test plan
- Reset, zero-wait memory where mem[a]=a|1 → IF/ID PCs 0,4,8,… with INSTRUCTION 1,5,9,… on consecutive cycles and VALID=1 from the second cycle after reset.
- IMEM_BUSY high for 3 cycles on address 8 → IMEM_ADDRESS stays 8 for those 3 cycles, 3 bubbles (VALID=0) appear, then PC=8 appears exactly once.
- STALL for 2 cycles while PC=4 is in IF/ID → IF/ID holds PC=4, no request is issued in HOLD, then PC=8 and then PC=12 follow with no gap or duplicate.
- BRANCH_TAKEN, target 0x100, asserted while the request to 0x10 is busy → 0x10 data dropped, VALID stays 0, next fetch goes to 0x100, and the first VALID instruction has PC=0x100.
- BRANCH_TAKEN and STALL in the same cycle while in HOLD → skid buffer dropped, IF/ID=NOP with VALID=0, FETCH_PC=target.
- RESET asserted mid-DISCARD → next cycle state=FETCH, IMEM_ADDRESS=RESET_PC, VALID=0.
